seg_display_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment display controller with LED mirror for the board I/O path.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_decoder.sv | 15 +
 rtl/seg_display_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path.
//   SEG_OFF  : all segments and DP dark (active-low).
//   SEG_HEX  : active-low g..a glyphs for hex digits 0..F, indexed by nibble.
//   seg_clog2: counter width helper, never narrower than one bit.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Index 15 (F) first, index 0 (0) last.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int unsigned seg_clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble + decimal point to active-low segment pattern (purely combinational).
//   nibble : hex digit 0..F
//   dp     : decimal point request, 1 = lit
//   seg_c  : {DP, g..a}, active-low
module seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg_c
);

   assign seg_c = {~dp, SEG_HEX[nibble]};

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode 7-segment controller with LED mirror.
//   MCLK, RSTN : clock, async active-low reset
//   VALUE      : hex value, digit k = VALUE[4k+3:4k]
//   DP_IN      : per-digit decimal point, 1 = lit
//   LOAD       : capture VALUE/DP_IN into the shadow; committed at next frame boundary
//   BLANK_LZ   : leading-zero blanking enable
//   BLINK_EN   : whole-display blink enable
//   BRIGHT     : PWM brightness code, all-ones = full duty
//   PC / LED   : LED is a registered copy of PC
//   ANODE, SEG : active-low digit enables and {DP, g..a} segments
//   FRAME      : one-cycle pulse after the digit index wraps to 0
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV_W      = 14,
   parameter int unsigned BRIGHT_W   = 3,
   parameter int unsigned BLINK_FR   = 64,
   parameter int unsigned LED_W      = 8
) (
   input  logic                    MCLK,
   input  logic                    RSTN,
   input  logic [4*NUM_DIGITS-1:0] VALUE,
   input  logic [NUM_DIGITS-1:0]   DP_IN,
   input  logic                    LOAD,
   input  logic                    BLANK_LZ,
   input  logic                    BLINK_EN,
   input  logic [BRIGHT_W-1:0]     BRIGHT,
   input  logic [LED_W-1:0]        PC,
   output logic [LED_W-1:0]        LED,
   output logic [NUM_DIGITS-1:0]   ANODE,
   output logic [7:0]              SEG,
   output logic                    FRAME
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = seg_clog2(NUM_DIGITS);
   localparam int unsigned BLK_W = seg_clog2(BLINK_FR);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FR - 1);

   logic [DIV_W-1:0]      slot_cnt;
   logic [IDX_W-1:0]      dig_idx;
   logic [VAL_W-1:0]      shadow_val;
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic                  pending;
   logic [VAL_W-1:0]      disp_val;
   logic [NUM_DIGITS-1:0] disp_dp;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_off;

   logic                  slot_wrap_c;
   logic                  frame_bnd_c;
   logic [NUM_DIGITS-1:0] lz_mask_c;
   logic [3:0]            cur_nib_c;
   logic                  cur_dp_c;
   logic                  cur_blank_c;
   logic [7:0]            dec_seg_c;
   logic                  lit_c;
   logic [NUM_DIGITS-1:0] anode_c;

   assign slot_wrap_c = (slot_cnt == {DIV_W{1'b1}});
   assign frame_bnd_c = slot_wrap_c && (dig_idx == LAST_IDX);

   // Slot and digit scan counters.
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         slot_cnt <= '0;
         dig_idx  <= '0;
      end else begin
         slot_cnt <= slot_cnt + DIV_W'(1);
         if (slot_wrap_c) begin
            dig_idx <= (dig_idx == LAST_IDX) ? '0 : dig_idx + IDX_W'(1);
         end
      end
   end

   // Shadow/display registers: the display only changes on a frame boundary.
   // A LOAD coinciding with the boundary commits the old shadow and stays pending.
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
      end else begin
         if (frame_bnd_c && pending) begin
            disp_val <= shadow_val;
            disp_dp  <= shadow_dp;
         end
         if (LOAD) begin
            shadow_val <= VALUE;
            shadow_dp  <= DP_IN;
            pending    <= 1'b1;
         end else if (frame_bnd_c) begin
            pending <= 1'b0;
         end
      end
   end

   // Blink phase toggles every BLINK_FR frames; disabling blink restarts it lit.
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (!BLINK_EN) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (frame_bnd_c) begin
         if (blink_cnt == LAST_BLK) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end
      end
   end

   // Leading-zero mask: run of zero nibbles from the top digit down; digit 0 never blanked.
   always_comb begin : lz_mask
      logic zero_run;
      zero_run  = BLANK_LZ;
      lz_mask_c = '0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
         zero_run     = zero_run && (disp_val[4*k +: 4] == 4'h0);
         lz_mask_c[k] = zero_run;
      end
   end

   // Select the nibble, DP and blank flag for the digit being scanned.
   always_comb begin
      cur_nib_c   = '0;
      cur_dp_c    = 1'b0;
      cur_blank_c = 1'b0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (dig_idx == IDX_W'(k)) begin
            cur_nib_c   = disp_val[4*k +: 4];
            cur_dp_c    = disp_dp[k];
            cur_blank_c = lz_mask_c[k];
         end
      end
   end

   seg_decoder u_dec (
      .nibble (cur_nib_c),
      .dp     (cur_dp_c),
      .seg_c  (dec_seg_c)
   );

   // PWM window on the top slot bits, gated by the blink phase.
   always_comb begin
      lit_c   = (slot_cnt[DIV_W-1 -: BRIGHT_W] <= BRIGHT) && !(BLINK_EN && blink_off);
      anode_c = lit_c ? ~(NUM_DIGITS'(1) << dig_idx) : '1;
   end

   // Output registers.
   always_ff @(posedge MCLK or negedge RSTN) begin
      if (!RSTN) begin
         LED   <= '0;
         ANODE <= '1;
         SEG   <= SEG_OFF;
         FRAME <= 1'b0;
      end else begin
         LED   <= PC;
         ANODE <= anode_c;
         SEG   <= cur_blank_c ? SEG_OFF : dec_seg_c;
         FRAME <= frame_bnd_c;
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: 4-digit instance checked against a time-based
// reference model, plus a 3-digit instance for non-power-of-2 scanning.
module tb_seg_display_ctrl;

   logic        mclk, rstn;
   logic [15:0] value;
   logic [11:0] value3;
   logic [3:0]  dp_in;
   logic        load, blank_lz, blink_en;
   logic [1:0]  bright;
   logic [7:0]  pc;
   logic [7:0]  led, seg, led3, seg3;
   logic [3:0]  anode;
   logic [2:0]  anode3;
   logic        frame, frame3;

   int checks, failures;

   // Reference model state: t = clock edges since reset release.
   int          t;
   logic [15:0] m_shadow, m_disp;
   logic [3:0]  m_shdp, m_dp;
   bit          m_pend;
   int          m_bframes;
   logic [3:0]  e_anode;
   logic [7:0]  e_seg, e_led;
   logic        e_frame;

   seg_display_ctrl #(.NUM_DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .BLINK_FR(2), .LED_W(8)) dut (
      .MCLK(mclk), .RSTN(rstn), .VALUE(value), .DP_IN(dp_in), .LOAD(load),
      .BLANK_LZ(blank_lz), .BLINK_EN(blink_en), .BRIGHT(bright), .PC(pc),
      .LED(led), .ANODE(anode), .SEG(seg), .FRAME(frame));

   seg_display_ctrl #(.NUM_DIGITS(3), .DIV_W(4), .BRIGHT_W(2), .BLINK_FR(2), .LED_W(8)) dut3 (
      .MCLK(mclk), .RSTN(rstn), .VALUE(value3), .DP_IN(dp_in[2:0]), .LOAD(load),
      .BLANK_LZ(blank_lz), .BLINK_EN(blink_en), .BRIGHT(bright), .PC(pc),
      .LED(led3), .ANODE(anode3), .SEG(seg3), .FRAME(frame3));

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   // Standard lit-segment sets (bit0 = a ... bit6 = g), active-high.
   function automatic logic [6:0] glyph_on(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // A digit is a blanked leading zero when it and every digit above it are zero.
   function automatic logic [7:0] ref_seg(input logic [15:0] val, input logic [3:0] dp,
                                          input int dig, input bit lz);
      logic [15:0] upper;
      upper = val >> (4 * dig);
      if (lz && dig != 0 && upper == 16'h0) return 8'hFF;
      return {~dp[dig], ~glyph_on(upper[3:0])};
   endfunction

   // Advance the model by the clock edge that just occurred, using the inputs it saw.
   task automatic model_step();
      int slot, dig;
      bit bnd, lit, phase_off;
      if (!rstn) begin
         t = 0; m_shadow = '0; m_disp = '0; m_shdp = '0; m_dp = '0; m_pend = 0; m_bframes = 0;
         e_anode = 4'hF; e_seg = 8'hFF; e_frame = 1'b0; e_led = 8'h00;
         return;
      end
      slot      = t % 16;
      dig       = (t / 16) % 4;
      bnd       = (t % 64) == 63;
      phase_off = ((m_bframes / 2) % 2) == 1;
      lit       = ((slot / 4) <= int'(bright)) && !(blink_en && phase_off);
      e_anode   = lit ? ~(4'b0001 << dig) : 4'hF;
      e_seg     = ref_seg(m_disp, m_dp, dig, blank_lz);
      e_frame   = bnd;
      e_led     = pc;
      if (bnd && m_pend) begin m_disp = m_shadow; m_dp = m_shdp; end
      if (bnd) m_pend = 0;
      if (load) begin m_shadow = value; m_shdp = dp_in; m_pend = 1; end
      if (!blink_en) m_bframes = 0;
      else if (bnd) m_bframes++;
      t++;
   endtask

   task automatic tick();
      @(negedge mclk);
      model_step();
   endtask

   task automatic wait_frame(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (frame === 1'b1) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; pc = 8'h5A; bright = 2'd3;
      repeat (3) tick();
      checks++; if (anode !== 4'hF) begin failures++; $display("FAIL reset_anode: got %h want f", anode); end
      checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h want ff", seg); end
      checks++; if (led !== 8'h00) begin failures++; $display("FAIL reset_led: got %h want 00", led); end
      checks++; if (frame !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b want 0", frame); end
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (anode !== 4'b1110 || seg !== 8'hC0) begin
            failures++; $display("FAIL release_digit0 i=%0d: got an=%b seg=%h want an=1110 seg=c0", i, anode, seg);
         end
      end
   endtask

   task automatic test_scan();
      bit ok;
      logic [7:0] tab [4];
      logic [3:0] exp_an;
      int d;
      tab[0] = 8'h99; tab[1] = 8'hB0; tab[2] = 8'hA4; tab[3] = 8'hF9;
      blank_lz = 1'b0; dp_in = 4'h0; value = 16'h1234; load = 1'b1;
      tick();
      load = 1'b0;
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL scan_frame_timeout: got none want pulse"); end
      for (int i = 0; i < 64; i++) begin
         tick();
         d = i / 16;
         exp_an = ~(4'b0001 << d);
         checks++;
         if (anode !== exp_an || seg !== tab[d]) begin
            failures++; $display("FAIL scan_digit i=%0d: got an=%b seg=%h want an=%b seg=%h", i, anode, seg, exp_an, tab[d]);
         end
         checks++;
         if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
            failures++; $display("FAIL scan_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
         end
      end
      checks++; if (frame !== 1'b1) begin failures++; $display("FAIL frame_period: got %b want 1 after 64 cycles", frame); end
   endtask

   task automatic test_tear_free();
      bit seen_a;
      int after;
      seen_a = 0; after = -1;
      for (int i = 0; i < 300 && (t % 64) != 20; i++) tick();
      value = 16'hAAAA; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 300 && (t % 64) != 40; i++) tick();
      value = 16'h5555; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 130; i++) begin
         tick();
         if (seg === 8'h88) seen_a = 1;
         checks++;
         if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
            failures++; $display("FAIL tear_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
         end
         if (after >= 0 && after < 64) begin
            checks++;
            if (seg !== 8'h92) begin failures++; $display("FAIL tear_new_glyph k=%0d: got %h want 92", after, seg); end
            after++;
         end else if (after < 0 && frame === 1'b1) begin
            after = 0;
         end
      end
      checks++; if (seen_a) begin failures++; $display("FAIL tear_no_a: got A glyph shown want never"); end
      checks++; if (after != 64) begin failures++; $display("FAIL tear_commit: got %0d new cycles want 64", after); end
   endtask

   task automatic test_lz_blank();
      bit ok;
      logic [7:0] tab [4];
      int d;
      blank_lz = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            value = 16'h00A0; dp_in = 4'b1101;
            tab[0] = 8'h40; tab[1] = 8'h88; tab[2] = 8'hFF; tab[3] = 8'hFF;
         end else begin
            value = 16'h0000; dp_in = 4'b1111;
            tab[0] = 8'h40; tab[1] = 8'hFF; tab[2] = 8'hFF; tab[3] = 8'hFF;
         end
         load = 1'b1;
         tick();
         load = 1'b0;
         wait_frame(ok);
         checks++; if (!ok) begin failures++; $display("FAIL lz_frame_timeout: got none want pulse"); end
         for (int i = 0; i < 64; i++) begin
            tick();
            d = i / 16;
            checks++;
            if (seg !== tab[d]) begin failures++; $display("FAIL lz_seg pass=%0d digit=%0d: got %h want %h", pass, d, seg, tab[d]); end
            checks++;
            if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
               failures++; $display("FAIL lz_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_bright_blink();
      bit ok;
      int lowcnt [4];
      int litcnt, want;
      value = 16'h8888; dp_in = 4'h0; load = 1'b1;
      tick();
      load = 1'b0; bright = 2'd0;
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL bright_frame_timeout: got none want pulse"); end
      for (int d = 0; d < 4; d++) lowcnt[d] = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (anode[i/16] === 1'b0) lowcnt[i/16]++;
         checks++;
         if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
            failures++; $display("FAIL bright_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
         end
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (lowcnt[d] != 4) begin failures++; $display("FAIL bright_duty digit=%0d: got %0d want 4", d, lowcnt[d]); end
      end
      bright = 2'd3;
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL blink_frame_timeout: got none want pulse"); end
      blink_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         litcnt = 0;
         for (int c = 0; c < 64; c++) begin
            tick();
            if (anode !== 4'hF) litcnt++;
            checks++;
            if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
               failures++; $display("FAIL blink_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
            end
         end
         want = (((f / 2) % 2) == 0) ? 64 : 0;
         checks++;
         if (litcnt != want) begin failures++; $display("FAIL blink_frame f=%0d: got %0d lit cycles want %0d", f, litcnt, want); end
      end
      blink_en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         tick();
         checks++;
         if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
            failures++; $display("FAIL rand_model t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
         end
         pc   = 8'($urandom);
         load = ($urandom_range(0, 15) == 0);
         if (load) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            case ($urandom_range(0, 3))
               0: value &= 16'h00FF;
               1: value &= 16'h000F;
               2: value = 16'h0000;
               default: ;
            endcase
         end
         if ($urandom_range(0, 63) == 0) bright = 2'($urandom);
         if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 299) == 0) blink_en = ~blink_en;
      end
      load = 1'b0;
   endtask

   task automatic test_n3_async_reset();
      logic [2:0] exp3;
      bright = 2'd3; blink_en = 1'b0; blank_lz = 1'b0; load = 1'b0; pc = 8'hC3;
      tick();
      tick();
      @(posedge mclk);
      #2 rstn = 1'b0;
      #1;
      checks++; if (anode !== 4'hF) begin failures++; $display("FAIL async_anode: got %h want f", anode); end
      checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL async_seg: got %h want ff", seg); end
      checks++; if (led !== 8'h00) begin failures++; $display("FAIL async_led: got %h want 00", led); end
      checks++; if (anode3 !== 3'h7) begin failures++; $display("FAIL async_anode3: got %h want 7", anode3); end
      checks++; if (seg3 !== 8'hFF || led3 !== 8'h00) begin failures++; $display("FAIL async_out3: got seg=%h led=%h want ff/00", seg3, led3); end
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         exp3 = ~(3'b001 << ((i / 16) % 3));
         checks++;
         if (anode3 !== exp3 || seg3 !== 8'hC0) begin
            failures++; $display("FAIL n3_scan i=%0d: got an=%b seg=%h want an=%b seg=c0", i, anode3, seg3, exp3);
         end
         checks++;
         if (frame3 !== ((i % 48) == 47)) begin failures++; $display("FAIL n3_frame i=%0d: got %b want %b", i, frame3, (i % 48) == 47); end
         checks++;
         if ({anode, seg, frame, led} !== {e_anode, e_seg, e_frame, e_led}) begin
            failures++; $display("FAIL n3_model4 t=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", t, anode, seg, frame, led, e_anode, e_seg, e_frame, e_led);
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rstn = 1'b0; value = '0; value3 = 12'h000; dp_in = '0; load = 1'b0;
      blank_lz = 1'b0; blink_en = 1'b0; bright = 2'd3; pc = '0;
      t = 0; m_shadow = '0; m_disp = '0; m_shdp = '0; m_dp = '0; m_pend = 0; m_bframes = 0;
      e_anode = 4'hF; e_seg = 8'hFF; e_frame = 1'b0; e_led = 8'h00;
      test_reset();
      test_scan();
      test_tear_free();
      test_lz_blank();
      test_bright_blink();
      test_random();
      test_n3_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
